pe_array_os: RTL and testbench
==============================

Name: pe_array_os

Overview:
- Parametrised output-stationary systolic MAC array; successor to the flat per-PE array.
- Computes C[ROWS x COLS] = A[ROWS x K] * B[K x COLS] with runtime K.
- Operand skew is generated internally; rows of C are drained through a valid/ready port with optional ReLU.
- Sits between the operand buffers and the activation/writeback path in the compute cluster.

Parameters:
- ROWS, 4, array rows; also the number of A lanes and output rows.
- COLS, 4, array columns; also the number of B lanes and output lanes.
- DATA_WIDTH, 8, signed operand width.
- ACC_WIDTH, 24, signed accumulator and output width; must be at least 2*DATA_WIDTH.
- K_WIDTH, 9, width of cfg_k; maximum K = 2^K_WIDTH-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin a tile; sampled only in IDLE.
- cfg_k  in  K_WIDTH  reduction length; captured on the accepted start.
- cfg_relu  in  1  apply ReLU at drain; captured on the accepted start.
- busy  out  1  high in every state except IDLE.
- a_data  in  ROWS*DATA_WIDTH  one A column, lane r = A[r][k].
- b_data  in  COLS*DATA_WIDTH  one B row, lane c = B[k][c].
- ab_valid  in  1  a_data and b_data are valid together.
- ab_ready  out  1  high only in COMPUTE.
- out_data  out  COLS*ACC_WIDTH  one row of C.
- out_row  out  $clog2(ROWS)  index of the presented row.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts.
- done  out  1  one-cycle pulse after the last row is accepted.

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE; busy, ab_ready, out_valid and done are 0; out_data and out_row are 0; accumulators, skew registers and counters are 0.
- FSM states: IDLE, COMPUTE, FLUSH, DRAIN.
- IDLE -> COMPUTE on start with cfg_k != 0.
  - Latch cfg_k and cfg_relu.
  - Clear all accumulators and skew registers that cycle.
- IDLE -> FLUSH on start with cfg_k == 0. Accumulators are cleared, so zeros are drained.
- COMPUTE:
  - A beat is ab_valid && ab_ready.
  - The array advances one step only on a beat; with no beat, all state holds.
  - After the K-th beat, go to FLUSH.
- FLUSH:
  - The array advances every cycle with zero operands injected.
  - Lasts exactly ROWS+COLS-1 cycles, then go to DRAIN.
- Array step:
  - A lane r passes through an r-stage delay line into PE(r,0); B lane c passes through a c-stage delay line into PE(0,c).
  - Each PE registers a eastward and b southward, and does acc += a*b.
  - Product is a signed 2*DATA_WIDTH value, sign-extended to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH; there is no saturation.
- DRAIN:
  - out_valid asserts the cycle after entry, with out_row=0.
  - Lane c of out_data = acc(out_row,c); if the latched relu is set, negative values become 0.
  - out_data and out_row are stable while out_valid && !out_ready.
  - On each handshake, out_row increments.
  - After row ROWS-1 is accepted: out_valid=0, pulse done for one cycle, go to IDLE.
- start while busy: ignored, with no effect on cfg.
- Back-to-back tiles: start may be asserted in the same cycle done pulses is not required; start is accepted the first cycle state is IDLE.
- rst mid-operation: immediate return to reset values. A partial tile is discarded and done is not pulsed.
- Stalled beats: ab_valid low for any number of cycles in COMPUTE does not change the result.

Decomposition:
- Shared package npu_pkg holds:
  - the state encoding enum pe_os_state_t;
  - default DATA_WIDTH and ACC_WIDTH localparams;
  - a function relu_acc(ACC_WIDTH).
- Natural sub-module: pe_mac_os, a single PE cell containing the operand pass-through registers, the accumulator, and inputs step and clear.
- The array top owns the FSM, skew delay lines, counters and drain mux.

Test Plan:
- Identity: 4x4, K=4, A=I, B[k][c]=k*4+c, ab_valid held high -> rows drained equal B; done pulses once; beats accepted = 4.
- Stall robustness: same tile with ab_valid toggling 1,0,0,1 and out_ready random -> identical out_data; out_row sequence 0,1,2,3; data held while stalled.
- Signed/ReLU: K=1, A=-3 all lanes, B=5 all lanes, relu=0 -> all -15 (0xFFFFF1); repeat with relu=1 -> all 0.
- Wrap: K=511, A=-128, B=-128 -> each acc = 511*16384 = 8372224 (fits); K=511 with ACC_WIDTH=16 build -> value modulo 2^16 = 49152, interpreted signed = -16384.
- K=0 and start-while-busy: start with cfg_k=0 -> busy, 4 zero rows, done; a second start mid-COMPUTE with cfg_k=1 -> ignored, first tile's K and results used.
- Reset mid-tile: assert rst after 2 of 4 beats -> busy=0 and ab_ready=0 immediately; a new tile afterwards gives correct results with no residue.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared definitions for the output-stationary MAC array: FSM encoding,
// default datapath widths and the drain-side ReLU helper.
package npu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DRAIN   = 2'd3
    } pe_os_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 24;
    localparam int RELU_W         = 64;

    // Callers sign-extend their ACC_WIDTH value to RELU_W and truncate the result back.
    function automatic logic signed [RELU_W-1:0] relu_acc(input logic signed [RELU_W-1:0] v);
        return v[RELU_W-1] ? '0 : v;
    endfunction

endpackage

// File: rtl/pe_mac_os.sv
// One output-stationary PE: forwards a east and b south through registers and
// accumulates a*b whenever the array steps.
module pe_mac_os
    import npu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         step,
    input  logic                         clear,
    input  logic signed [DATA_WIDTH-1:0] a_in,
    input  logic signed [DATA_WIDTH-1:0] b_in,
    output logic signed [DATA_WIDTH-1:0] a_out,
    output logic signed [DATA_WIDTH-1:0] b_out,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    logic signed [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic signed [2*DATA_WIDTH-1:0] prod;

    assign prod = a_in * b_in;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (clear) begin
            a_d   = '0;
            b_d   = '0;
            acc_d = '0;
        end else if (step) begin
            a_d   = a_in;
            b_d   = b_in;
            // Signed cast sign-extends the product; the sum wraps with no saturation.
            acc_d = acc_q + ACC_WIDTH'(prod);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/pe_array_os.sv
// Output-stationary systolic array computing C = A*B with runtime K; skews the
// operand lanes internally and drains C one row at a time over valid/ready.
module pe_array_os
    import npu_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int K_WIDTH    = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [K_WIDTH-1:0]           cfg_k,
    input  logic                         cfg_relu,
    output logic                         busy,
    input  logic [ROWS*DATA_WIDTH-1:0]   a_data,
    input  logic [COLS*DATA_WIDTH-1:0]   b_data,
    input  logic                         ab_valid,
    output logic                         ab_ready,
    output logic [COLS*ACC_WIDTH-1:0]    out_data,
    output logic [$clog2(ROWS)-1:0]      out_row,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         done
);

    localparam int RW     = $clog2(ROWS);
    localparam int FL_CYC = ROWS + COLS - 1;
    localparam int FW     = $clog2(FL_CYC + 1);

    pe_os_state_t             state_q, state_d;
    logic [K_WIDTH-1:0]       k_lat_q, k_lat_d, k_cnt_q, k_cnt_d;
    logic                     relu_q, relu_d;
    logic [FW-1:0]            fl_cnt_q, fl_cnt_d;
    logic [COLS*ACC_WIDTH-1:0] out_data_q, out_data_d, drain_row;
    logic [RW-1:0]            out_row_q, out_row_d, sel_row;
    logic                     out_valid_q, out_valid_d, done_q, done_d;
    logic                     step, clear;

    logic signed [DATA_WIDTH-1:0] a_w   [ROWS][COLS+1];
    logic signed [DATA_WIDTH-1:0] b_w   [ROWS+1][COLS];
    logic signed [ACC_WIDTH-1:0]  acc_w [ROWS][COLS];

    assign clear = (state_q == ST_IDLE) && start;
    assign step  = ((state_q == ST_COMPUTE) && ab_valid) || (state_q == ST_FLUSH);

    genvar gi, gj;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_a_skew
            logic signed [DATA_WIDTH-1:0] inj;
            assign inj = (state_q == ST_COMPUTE) ? a_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
            if (gi == 0) begin : g_direct
                assign a_w[gi][0] = inj;
            end else begin : g_delay
                logic signed [DATA_WIDTH-1:0] dl_q [gi];
                logic signed [DATA_WIDTH-1:0] dl_d [gi];
                always_comb begin
                    for (int i = 0; i < gi; i++) dl_d[i] = dl_q[i];
                    if (clear) begin
                        for (int i = 0; i < gi; i++) dl_d[i] = '0;
                    end else if (step) begin
                        dl_d[0] = inj;
                        for (int i = 1; i < gi; i++) dl_d[i] = dl_q[i-1];
                    end
                end
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int i = 0; i < gi; i++) dl_q[i] <= '0;
                    end else begin
                        for (int i = 0; i < gi; i++) dl_q[i] <= dl_d[i];
                    end
                end
                assign a_w[gi][0] = dl_q[gi-1];
            end
        end

        for (gj = 0; gj < COLS; gj++) begin : g_b_skew
            logic signed [DATA_WIDTH-1:0] inj;
            assign inj = (state_q == ST_COMPUTE) ? b_data[gj*DATA_WIDTH +: DATA_WIDTH] : '0;
            if (gj == 0) begin : g_direct
                assign b_w[0][gj] = inj;
            end else begin : g_delay
                logic signed [DATA_WIDTH-1:0] dl_q [gj];
                logic signed [DATA_WIDTH-1:0] dl_d [gj];
                always_comb begin
                    for (int i = 0; i < gj; i++) dl_d[i] = dl_q[i];
                    if (clear) begin
                        for (int i = 0; i < gj; i++) dl_d[i] = '0;
                    end else if (step) begin
                        dl_d[0] = inj;
                        for (int i = 1; i < gj; i++) dl_d[i] = dl_q[i-1];
                    end
                end
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int i = 0; i < gj; i++) dl_q[i] <= '0;
                    end else begin
                        for (int i = 0; i < gj; i++) dl_q[i] <= dl_d[i];
                    end
                end
                assign b_w[0][gj] = dl_q[gj-1];
            end
            logic unused_b_south;
            assign unused_b_south = ^b_w[ROWS][gj];
        end

        for (gi = 0; gi < ROWS; gi++) begin : g_row
            for (gj = 0; gj < COLS; gj++) begin : g_col
                pe_mac_os #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .ACC_WIDTH  (ACC_WIDTH)
                ) u_pe (
                    .clk   (clk),
                    .rst   (rst),
                    .step  (step),
                    .clear (clear),
                    .a_in  (a_w[gi][gj]),
                    .b_in  (b_w[gi][gj]),
                    .a_out (a_w[gi][gj+1]),
                    .b_out (b_w[gi+1][gj]),
                    .acc   (acc_w[gi][gj])
                );
            end
            logic unused_a_east;
            assign unused_a_east = ^a_w[gi][COLS];
        end
    endgenerate

    // First drain cycle loads row 0; each later handshake loads the next row.
    assign sel_row = out_valid_q ? out_row_q + RW'(1) : out_row_q;

    always_comb begin
        drain_row = '0;
        for (int c = 0; c < COLS; c++) begin
            drain_row[c*ACC_WIDTH +: ACC_WIDTH] = relu_q
                ? ACC_WIDTH'(relu_acc(RELU_W'(acc_w[sel_row][c])))
                : acc_w[sel_row][c];
        end
    end

    always_comb begin
        state_d     = state_q;
        k_lat_d     = k_lat_q;
        relu_d      = relu_q;
        k_cnt_d     = k_cnt_q;
        fl_cnt_d    = fl_cnt_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_lat_d  = cfg_k;
                    relu_d   = cfg_relu;
                    k_cnt_d  = '0;
                    fl_cnt_d = '0;
                    state_d  = (cfg_k != '0) ? ST_COMPUTE : ST_FLUSH;
                end
            end
            ST_COMPUTE: begin
                if (ab_valid) begin
                    k_cnt_d = k_cnt_q + K_WIDTH'(1);
                    if (k_cnt_q == k_lat_q - K_WIDTH'(1)) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                fl_cnt_d = fl_cnt_q + FW'(1);
                if (fl_cnt_q == FW'(FL_CYC - 1)) begin
                    state_d   = ST_DRAIN;
                    out_row_d = '0;
                end
            end
            ST_DRAIN: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = drain_row;
                end else if (out_ready) begin
                    if (out_row_q == RW'(ROWS - 1)) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        out_row_d  = out_row_q + RW'(1);
                        out_data_d = drain_row;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_lat_q     <= '0;
            relu_q      <= 1'b0;
            k_cnt_q     <= '0;
            fl_cnt_q    <= '0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_lat_q     <= k_lat_d;
            relu_q      <= relu_d;
            k_cnt_q     <= k_cnt_d;
            fl_cnt_q    <= fl_cnt_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign ab_ready  = (state_q == ST_COMPUTE);
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pe_array_os.sv
// Directed bench for pe_array_os: a 24-bit and a 16-bit accumulator build share
// stimulus; tiles are fed, drained and compared against hand-computed results.
module tb_pe_array_os;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int AW   = 24;
    localparam int AW16 = 16;
    localparam int KW   = 9;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [KW-1:0]          cfg_k = '0;
    logic                   cfg_relu = 1'b0;
    logic [ROWS*DW-1:0]     a_data = '0;
    logic [COLS*DW-1:0]     b_data = '0;
    logic                   ab_valid = 1'b0;
    logic                   out_ready = 1'b0;

    logic                   busy, ab_ready, out_valid, done;
    logic [COLS*AW-1:0]     out_data;
    logic [1:0]             out_row;
    logic                   busy16, ab_ready16, out_valid16, done16;
    logic [COLS*AW16-1:0]   out_data16;
    logic [1:0]             out_row16;

    int n_checks = 0;
    int n_errors = 0;

    logic signed [DW-1:0] a_mat [512][ROWS];
    logic signed [DW-1:0] b_mat [512][COLS];
    logic [AW-1:0]        exp24 [ROWS][COLS];
    logic [AW16-1:0]      exp16 [ROWS][COLS];

    typedef struct {
        int            k;
        bit            relu;
        int            a;
        int            b;
        logic [23:0]   e24;
        logic [15:0]   e16;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    pe_array_os #(
        .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_WIDTH(KW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_relu(cfg_relu),
        .busy(busy), .a_data(a_data), .b_data(b_data), .ab_valid(ab_valid),
        .ab_ready(ab_ready), .out_data(out_data), .out_row(out_row),
        .out_valid(out_valid), .out_ready(out_ready), .done(done)
    );

    pe_array_os #(
        .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW16), .K_WIDTH(KW)
    ) dut16 (
        .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_relu(cfg_relu),
        .busy(busy16), .a_data(a_data), .b_data(b_data), .ab_valid(ab_valid),
        .ab_ready(ab_ready16), .out_data(out_data16), .out_row(out_row16),
        .out_valid(out_valid16), .out_ready(out_ready), .done(done16)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input int k, input bit relu);
        cfg_k    = KW'(k);
        cfg_relu = relu;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic drive_beat(input int idx, input logic v);
        for (int r = 0; r < ROWS; r++) a_data[r*DW +: DW] = a_mat[idx][r];
        for (int c = 0; c < COLS; c++) b_data[c*DW +: DW] = b_mat[idx][c];
        ab_valid = v;
        tick();
    endtask

    // Feeds k beats, then offers two extra beats that must not be accepted.
    task automatic feed(input string name, input int k, input bit stall);
        int   beats = 0;
        int   n = 0;
        logic v;
        logic hs;
        while (beats < k && n < 4000) begin
            v  = stall ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
            hs = v && ab_ready;
            drive_beat(beats, v);
            if (hs) beats++;
            n++;
        end
        for (int i = 0; i < 2; i++) begin
            hs = ab_ready;
            drive_beat(k - 1, 1'b1);
            if (hs) beats++;
        end
        ab_valid = 1'b0;
        chk({name, "_beats"}, beats, k);
    endtask

    task automatic fill_uniform(input int k, input int a, input int b,
                                input logic [AW-1:0] e24, input logic [AW16-1:0] e16);
        for (int i = 0; i < k; i++) begin
            for (int r = 0; r < ROWS; r++) a_mat[i][r] = DW'(a);
            for (int c = 0; c < COLS; c++) b_mat[i][c] = DW'(b);
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                exp24[r][c] = e24;
                exp16[r][c] = e16;
            end
        end
    endtask

    task automatic drain(input string name, input bit rnd_ready);
        int                  n = 0;
        int                  row = 0;
        logic                rdy;
        logic                hs;
        logic [COLS*AW-1:0]  e24v;
        logic [COLS*AW16-1:0] e16v;
        while (!out_valid && n < 2000) begin
            tick();
            n++;
        end
        chk({name, "_valid_seen"}, out_valid, 1'b1);
        while (row < ROWS && n < 4000) begin
            rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                for (int c = 0; c < COLS; c++) begin
                    e24v[c*AW +: AW]     = exp24[row][c];
                    e16v[c*AW16 +: AW16] = exp16[row][c];
                end
                chk({name, "_row_idx"}, out_row, row);
                chk({name, "_data24"}, out_data, e24v);
                chk({name, "_valid16"}, out_valid16, 1'b1);
                chk({name, "_data16"}, out_data16, e16v);
            end
            hs        = out_valid && rdy;
            out_ready = rdy;
            tick();
            if (hs) row++;
            n++;
        end
        out_ready = 1'b0;
        chk({name, "_rows"}, row, ROWS);
        chk({name, "_done"}, done, 1'b1);
        chk({name, "_done16"}, done16, 1'b1);
        chk({name, "_valid_low"}, out_valid, 1'b0);
        chk({name, "_idle"}, busy, 1'b0);
        tick();
        chk({name, "_done_once"}, done, 1'b0);
    endtask

    initial begin
        vecs[0] = '{k: 1,   relu: 1'b0, a: -3,   b: 5,    e24: 24'hFFFFF1, e16: 16'hFFF1};
        vecs[1] = '{k: 1,   relu: 1'b1, a: -3,   b: 5,    e24: 24'h000000, e16: 16'h0000};
        vecs[2] = '{k: 511, relu: 1'b0, a: -128, b: -128, e24: 24'h7FC000, e16: 16'hC000};
        vecs[3] = '{k: 3,   relu: 1'b0, a: 7,    b: -2,   e24: 24'hFFFFD6, e16: 16'hFFD6};
        vecs[4] = '{k: 2,   relu: 1'b1, a: 10,   b: 6,    e24: 24'h000078, e16: 16'h0078};
        vecs[5] = '{k: 0,   relu: 1'b0, a: 9,    b: 9,    e24: 24'h000000, e16: 16'h0000};

        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_ab_ready", ab_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_row", out_row, '0);
        chk("rst16", {busy16, ab_ready16, out_valid16, done16, out_row16, out_data16}, '0);

        // Identity A with B[k][c] = 4k+c: drained rows reproduce B.
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < ROWS; r++) a_mat[k][r] = (r == k) ? 8'sd1 : 8'sd0;
            for (int c = 0; c < COLS; c++) b_mat[k][c] = DW'(k * 4 + c);
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                exp24[r][c] = AW'(r * 4 + c);
                exp16[r][c] = AW16'(r * 4 + c);
            end
        end
        start_tile(4, 1'b0);
        chk("ident_busy", busy, 1'b1);
        chk("ident_ab_ready", ab_ready, 1'b1);
        feed("ident", 4, 1'b0);
        drain("ident", 1'b0);

        start_tile(4, 1'b0);
        feed("stall", 4, 1'b1);
        drain("stall", 1'b1);

        for (int i = 0; i < 6; i++) begin
            fill_uniform(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].e24, vecs[i].e16);
            start_tile(vecs[i].k, vecs[i].relu);
            chk($sformatf("vec%0d_busy", i), busy, 1'b1);
            chk($sformatf("vec%0d_ab_ready", i), ab_ready, vecs[i].k != 0);
            if (vecs[i].k != 0) feed($sformatf("vec%0d", i), vecs[i].k, 1'b0);
            drain($sformatf("vec%0d", i), 1'b0);
        end

        // A second start mid-COMPUTE with K=1/relu=1 must not disturb the K=2 tile.
        fill_uniform(2, -2, 3, 24'hFFFFF4, 16'hFFF4);
        start_tile(2, 1'b0);
        drive_beat(0, 1'b1);
        cfg_k    = KW'(1);
        cfg_relu = 1'b1;
        start    = 1'b1;
        drive_beat(1, 1'b0);
        start    = 1'b0;
        chk("sib_still_compute", ab_ready, 1'b1);
        drive_beat(1, 1'b1);
        ab_valid = 1'b0;
        chk("sib_left_compute", ab_ready, 1'b0);
        drain("sib", 1'b0);

        // Reset after 2 of 4 beats, then a fresh tile must be clean.
        fill_uniform(4, 5, 5, 24'h000064, 16'h0064);
        start_tile(4, 1'b0);
        drive_beat(0, 1'b1);
        drive_beat(1, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ab_ready", ab_ready, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        ab_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        fill_uniform(1, 1, 4, 24'h000004, 16'h0004);
        start_tile(1, 1'b0);
        feed("post_rst", 1, 1'b0);
        drain("post_rst", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
